// File: rtl/serial_alu_adder_if.sv
// serial_alu_adder_if: start/done request bus between the sequencer and the serial adder
interface serial_alu_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CF_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             CF, ZF, SF, OF, AF, PF;
  modport master (output start, op, A, B, CF_in,
                  input  busy, done, Result, CF, ZF, SF, OF, AF, PF);
  modport slave  (input  start, op, A, B, CF_in,
                  output busy, done, Result, CF, ZF, SF, OF, AF, PF);
endinterface

// File: rtl/serial_alu_adder.sv
// serial_alu_adder: bit-serial 8086 ADD/ADC/SUB/SBB sharing one full_adder cell, LSB first
module half_adder (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B;
  assign Cout = A & B;
endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  logic s1, c1, c2;
  half_adder u_h0 (.A(A),  .B(B),   .Sum(s1),  .Cout(c1));
  half_adder u_h1 (.A(s1), .B(Cin), .Sum(Sum), .Cout(c2));
  assign Cout = c1 | c2;
endmodule

module serial_alu_adder #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst_n,
  serial_alu_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, res_q, res_d, sh_nx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, sub_q, sub_d, af3_q, af3_d;
  logic [5:0]       flg_q, flg_d;
  logic             sum, cout, accept, last;
  full_adder u_fa (.A(a_q[0]), .B(b_q[0]), .Cin(carry_q), .Sum(sum), .Cout(cout));
  assign accept = bus.start && state_q != RUN;
  assign last   = state_q == RUN && cnt_q == CW'(WIDTH - 1);
  assign sh_nx  = {sum, sh_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    af3_d   = af3_q;
    flg_d   = flg_q;
    if (accept) begin
      state_d = RUN;
      a_d     = bus.A;
      b_d     = bus.op[1] ? ~bus.B : bus.B;
      sub_d   = bus.op[1];
      cnt_d   = '0;
      carry_d = bus.op[1] ^ (bus.op[0] & bus.CF_in);
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sh_d    = sh_nx;
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      af3_d   = cnt_q == CW'(3) ? cout : af3_q;
      if (last) begin
        state_d = DONE;
        res_d   = sh_nx;
        // carry_q here is the carry into the MSB; CF/AF flip to borrow sense for subtraction
        flg_d   = {cout ^ sub_q, sh_nx == '0, sh_nx[WIDTH-1], carry_q ^ cout, af3_q ^ sub_q, ~^sh_nx[7:0]};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      af3_q   <= 1'b0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      af3_q   <= af3_d;
      flg_q   <= flg_d;
    end
  end
  assign bus.busy   = state_q == RUN;
  assign bus.done   = state_q == DONE;
  assign bus.Result = res_q;
  assign {bus.CF, bus.ZF, bus.SF, bus.OF, bus.AF, bus.PF} = flg_q;
endmodule
